// File: rtl/lt24_pixel_arbiter_if.sv
// Requester-side and LT24 pixel-port signals of lt24_pixel_arbiter.
// master is the arbiter's view; slave is the view shared by the requesters and the display driver.
interface lt24_pixel_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]    reqValid;
    logic [8*NUM_REQ-1:0]  reqX;
    logic [9*NUM_REQ-1:0]  reqY;
    logic [16*NUM_REQ-1:0] reqColour;
    logic [NUM_REQ-1:0]    reqAck;

    logic [7:0]            xAddr;
    logic [8:0]            yAddr;
    logic [15:0]           pixelData;
    logic                  pixelWrite;
    logic                  pixelReady;

    logic [GW-1:0]         grantId;
    logic                  busy;
    logic [15:0]           dropCount;

    modport master (
        input  reqValid, reqX, reqY, reqColour, pixelReady,
        output reqAck, xAddr, yAddr, pixelData, pixelWrite, grantId, busy, dropCount
    );

    modport slave (
        output reqValid, reqX, reqY, reqColour, pixelReady,
        input  reqAck, xAddr, yAddr, pixelData, pixelWrite, grantId, busy, dropCount
    );
endinterface

// File: rtl/lt24_pixel_arbiter.sv
// Round-robin arbiter sharing the LT24 pixel-write port among NUM_REQ producers;
// one pixel per grant, off-panel pixels are acked, dropped and counted.
module lt24_pixel_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 240,
    parameter int HEIGHT  = 320
) (
    input  logic                 clock,
    input  logic                 globalReset_n,
    input  logic                 resetApp,
    lt24_pixel_arbiter_if.master bus
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [8:0] X_LIMIT = 9'(WIDTH);
    localparam logic [9:0] Y_LIMIT = 10'(HEIGHT);

    typedef enum logic [1:0] {INIT, ARB, ISSUE, DROP} state_t;

    state_t        state;
    logic          found;
    logic [GW-1:0] pick;
    logic [7:0]    sel_x;
    logic [8:0]    sel_y;
    logic [15:0]   sel_colour;
    logic          in_range;

    // Search starts just after the last winner, so the winner drops to lowest priority.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (bus.reqValid[(int'(bus.grantId) + k) % NUM_REQ]) begin
                found = 1'b1;
                pick  = GW'((int'(bus.grantId) + k) % NUM_REQ);
            end
        end
    end

    assign sel_x      = bus.reqX[8*int'(pick) +: 8];
    assign sel_y      = bus.reqY[9*int'(pick) +: 9];
    assign sel_colour = bus.reqColour[16*int'(pick) +: 16];
    assign in_range   = ({1'b0, sel_x} < X_LIMIT) && ({1'b0, sel_y} < Y_LIMIT);

    // NOTE: state is updated with non-blocking assignments only, so every register
    // sees pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge globalReset_n) begin
        if (!globalReset_n) begin
            // NOTE: only control and output registers carry reset; there is no memory here.
            state          <= INIT;
            bus.reqAck     <= '0;
            bus.pixelWrite <= 1'b0;
            bus.xAddr      <= '0;
            bus.yAddr      <= '0;
            bus.pixelData  <= '0;
            bus.dropCount  <= '0;
            bus.busy       <= 1'b1;
            bus.grantId    <= GW'(NUM_REQ - 1);
        end else begin
            bus.reqAck <= '0;
            if (resetApp) begin
                state          <= INIT;
                bus.pixelWrite <= 1'b0;
                bus.busy       <= 1'b1;
            end else begin
                case (state)
                    INIT: begin
                        state    <= ARB;
                        bus.busy <= 1'b0;
                    end
                    ARB: begin
                        if (found) begin
                            bus.grantId <= pick;
                            bus.reqAck  <= NUM_REQ'(1) << pick;
                            bus.busy    <= 1'b1;
                            if (in_range) begin
                                bus.xAddr      <= sel_x;
                                bus.yAddr      <= sel_y;
                                bus.pixelData  <= sel_colour;
                                bus.pixelWrite <= 1'b1;
                                state          <= ISSUE;
                            end else begin
                                if (bus.dropCount != 16'hFFFF)
                                    bus.dropCount <= bus.dropCount + 16'd1;
                                state <= DROP;
                            end
                        end
                    end
                    ISSUE: begin
                        if (bus.pixelReady) begin
                            bus.pixelWrite <= 1'b0;
                            bus.busy       <= 1'b0;
                            state          <= ARB;
                        end
                    end
                    DROP: begin
                        bus.busy <= 1'b0;
                        state    <= ARB;
                    end
                    default: begin
                        bus.pixelWrite <= 1'b0;
                        bus.busy       <= 1'b1;
                        state          <= INIT;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_lt24_pixel_arbiter.sv
// Directed self-checking bench for lt24_pixel_arbiter (NUM_REQ=4, 240x320 panel).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_lt24_pixel_arbiter;
    logic clock;
    logic globalReset_n;
    logic resetApp;

    lt24_pixel_arbiter_if #(.NUM_REQ(4)) bus ();

    lt24_pixel_arbiter #(.NUM_REQ(4), .WIDTH(240), .HEIGHT(320)) dut (
        .clock         (clock),
        .globalReset_n (globalReset_n),
        .resetApp      (resetApp),
        .bus           (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int compared   = 0;
    int mismatched = 0;

    // Transfer and ack monitor on the falling edge, away from the active edge.
    int         xfers = 0;
    int         ack_cnt [4] = '{0, 0, 0, 0};
    logic [7:0] last_x;
    logic [8:0] last_y;
    logic [15:0] last_c;

    always @(negedge clock) begin
        if (globalReset_n) begin
            if (bus.pixelWrite && bus.pixelReady) begin
                xfers++;
                last_x = bus.xAddr;
                last_y = bus.yAddr;
                last_c = bus.pixelData;
            end
            for (int i = 0; i < 4; i++)
                if (bus.reqAck[i]) ack_cnt[i]++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [7:0] x,
                           input logic [8:0] y, input logic [15:0] c);
        bus.reqValid[i]          = v;
        bus.reqX[8*i +: 8]       = x;
        bus.reqY[9*i +: 9]       = y;
        bus.reqColour[16*i +: 16] = c;
    endtask

    // Steps until some reqAck bit is high; id = acked requester, n = cycles taken.
    task automatic wait_ack(input int budget, output int id, output int n);
        id = -1;
        n  = 0;
        while (n < budget) begin
            tick();
            n++;
            if (bus.reqAck != 4'b0000) begin
                for (int i = 0; i < 4; i++)
                    if (bus.reqAck[i]) id = i;
                return;
            end
        end
        compared++;
        mismatched++;
        $error("FAIL ack_timeout: observed no ack, expected one within %0d cycles", budget);
    endtask

    initial begin
        int id;
        int n;
        int base_x;
        int base_a [4];

        globalReset_n  = 1'b0;
        resetApp       = 1'b1;
        bus.pixelReady = 1'b0;
        bus.reqValid   = '0;
        bus.reqX       = '0;
        bus.reqY       = '0;
        bus.reqColour  = '0;
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 8'(3*i + 1), 9'(5*i + 2), 16'(16'h1111 * (i + 1)));

        // Reset values, then 20 cycles held in INIT by resetApp.
        repeat (3) tick();
        check("rst_pixelwrite", 64'(bus.pixelWrite), 64'd0);
        check("rst_busy",       64'(bus.busy),       64'd1);
        check("rst_grantid",    64'(bus.grantId),    64'd3);
        check("rst_data",       {bus.xAddr, bus.yAddr, bus.pixelData}, 64'd0);
        check("rst_dropcount",  64'(bus.dropCount),  64'd0);
        globalReset_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            check("init_hold", {bus.pixelWrite, bus.reqAck, bus.busy}, {1'b0, 4'b0000, 1'b1});
        end
        resetApp = 1'b0;
        wait_ack(6, id, n);
        check("first_ack_id", 64'(id), 64'd0);
        check("first_ack_latency", 64'(n), 64'd2);
        bus.reqValid   = '0;
        bus.pixelReady = 1'b1;
        tick();
        check("first_xfer_count", 64'(xfers), 64'd1);
        check("first_xfer_data", {last_x, last_y, last_c}, {8'd1, 9'd2, 16'h1111});

        // Requester 2 alone, in range.
        base_x = xfers;
        set_req(2, 1'b1, 8'd10, 9'd20, 16'hF800);
        wait_ack(4, id, n);
        check("solo_ack_id", 64'(id), 64'd2);
        check("solo_issue", {bus.pixelWrite, bus.xAddr, bus.yAddr, bus.pixelData}, {1'b1, 8'd10, 9'd20, 16'hF800});
        bus.reqValid = '0;
        tick();
        check("solo_ack_pulse", {bus.reqAck, bus.pixelWrite, bus.busy}, {4'b0000, 1'b0, 1'b0});
        check("solo_xfer_count", 64'(xfers - base_x), 64'd1);
        check("solo_xfer_data", {last_x, last_y, last_c}, {8'd10, 9'd20, 16'hF800});
        check("solo_grantid", 64'(bus.grantId), 64'd2);

        // All four held valid; last winner was 2, so the order is 3,0,1,2 repeated.
        base_x = xfers;
        for (int i = 0; i < 4; i++) base_a[i] = ack_cnt[i];
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 8'(3*i + 1), 9'(5*i + 2), 16'(16'h1111 * (i + 1)));
        for (int k = 0; k < 16; k++) begin
            wait_ack(4, id, n);
            check("rr_order", 64'(id), 64'((3 + k) % 4));
            check("rr_xaddr", 64'(bus.xAddr), 64'(3*((3 + k) % 4) + 1));
            if (k > 0) check("rr_gap", 64'(n), 64'd2);
        end
        bus.reqValid = '0;
        tick();
        check("rr_xfer_count", 64'(xfers - base_x), 64'd16);
        for (int i = 0; i < 4; i++) check("rr_ack_count", 64'(ack_cnt[i] - base_a[i]), 64'd4);

        // Stall: pixelReady low for 10 cycles in ISSUE while requester 3 waits.
        base_x = xfers;
        bus.pixelReady = 1'b0;
        set_req(1, 1'b1, 8'd50, 9'd60, 16'hABCD);
        wait_ack(4, id, n);
        check("stall_ack_id", 64'(id), 64'd1);
        bus.reqValid[1] = 1'b0;
        set_req(3, 1'b1, 8'd70, 9'd80, 16'h1234);
        for (int c = 0; c < 10; c++) begin
            tick();
            check("stall_hold", {bus.pixelWrite, bus.reqAck, bus.xAddr, bus.yAddr, bus.pixelData},
                  {1'b1, 4'b0000, 8'd50, 9'd60, 16'hABCD});
        end
        check("stall_no_xfer", 64'(xfers - base_x), 64'd0);
        bus.pixelReady = 1'b1;
        tick();
        check("stall_one_xfer", 64'(xfers - base_x), 64'd1);
        check("stall_xfer_data", {last_x, last_y, last_c}, {8'd50, 9'd60, 16'hABCD});
        wait_ack(4, id, n);
        check("stall_next_id", 64'(id), 64'd3);
        bus.reqValid = '0;
        tick();

        // Out-of-range drops from requester 1, then a corner pixel that transfers.
        base_x = xfers;
        set_req(1, 1'b1, 8'd240, 9'd0, 16'h0001);
        wait_ack(4, id, n);
        check("drop1_id", 64'(id), 64'd1);
        check("drop1_state", {bus.pixelWrite, bus.busy, bus.dropCount}, {1'b0, 1'b1, 16'd1});
        set_req(1, 1'b1, 8'd0, 9'd320, 16'h0002);
        wait_ack(4, id, n);
        check("drop2_gap", 64'(n), 64'd2);
        check("drop2_state", {bus.pixelWrite, bus.dropCount}, {1'b0, 16'd2});
        set_req(1, 1'b1, 8'd239, 9'd319, 16'h07E0);
        wait_ack(4, id, n);
        check("corner_issue", {bus.pixelWrite, bus.xAddr, bus.yAddr, bus.dropCount},
              {1'b1, 8'd239, 9'd319, 16'd2});
        bus.reqValid = '0;
        tick();
        check("corner_xfer_count", 64'(xfers - base_x), 64'd1);
        check("corner_xfer_data", {last_x, last_y, last_c}, {8'd239, 9'd319, 16'h07E0});

        // resetApp mid-ISSUE discards the pixel, keeps dropCount, re-enters INIT.
        base_x = xfers;
        bus.pixelReady = 1'b0;
        set_req(0, 1'b1, 8'd1, 9'd2, 16'h0003);
        wait_ack(4, id, n);
        check("ra_ack_id", 64'(id), 64'd0);
        bus.reqValid = '0;
        tick();
        check("ra_issuing", 64'(bus.pixelWrite), 64'd1);
        resetApp = 1'b1;
        tick();
        check("ra_cleared", {bus.pixelWrite, bus.busy, bus.reqAck, bus.dropCount},
              {1'b0, 1'b1, 4'b0000, 16'd2});
        resetApp = 1'b0;
        set_req(2, 1'b1, 8'd5, 9'd6, 16'h0004);
        wait_ack(4, id, n);
        check("ra_reinit_latency", 64'(n), 64'd2);
        check("ra_next_id", 64'(id), 64'd2);
        bus.reqValid = '0;
        tick();
        check("ra_issuing2", 64'(bus.pixelWrite), 64'd1);

        // globalReset_n pulse mid-ISSUE: outputs clear without waiting for an edge.
        #2 globalReset_n = 1'b0;
        #1;
        check("gr_immediate", {bus.pixelWrite, bus.busy, bus.reqAck, bus.grantId, bus.dropCount},
              {1'b0, 1'b1, 4'b0000, 2'd3, 16'd0});
        check("gr_no_xfer", 64'(xfers - base_x), 64'd0);
        set_req(0, 1'b1, 8'd9, 9'd9, 16'h0009);
        set_req(3, 1'b1, 8'd8, 9'd8, 16'h0008);
        bus.pixelReady = 1'b1;
        #2 globalReset_n = 1'b1;
        wait_ack(4, id, n);
        check("gr_first_id", 64'(id), 64'd0);
        check("gr_first_latency", 64'(n), 64'd2);
        bus.reqValid = '0;
        tick();
        check("gr_xfer_data", {last_x, last_y, last_c}, {8'd9, 9'd9, 16'h0009});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
